sdram_burst_scheduler: RTL and testbench

Arbitrates four FIFO-backed ports (two write, two read) onto the single host-side request interface of the SDRAM controller. It watches FIFO fill levels and picks one eligible port by round-robin. It then presents that port's burst address and a held WR or RD request, and steers the controller's IN_REQ/OUT_VALID strobes to the granted FIFO. It keeps one wrapping address pointer per port.

---
 rtl/sdram_burst_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_scheduler.sv
// Round-robin burst scheduler: picks one of two write / two read FIFO ports,
// presents its burst request to the SDRAM controller and steers data strobes.
module sdram_burst_scheduler #(
  parameter int ASIZE      = 22,
  parameter int USEDW_W    = 9,
  parameter int FIFO_DEPTH = 256,
  parameter int BURST      = 8
) (
  input  logic               REF_CLK,
  input  logic               RESET_N,
  input  logic [USEDW_W-1:0] WR1_USEDW,
  input  logic [USEDW_W-1:0] WR2_USEDW,
  input  logic [USEDW_W-1:0] RD1_USEDW,
  input  logic [USEDW_W-1:0] RD2_USEDW,
  input  logic               RD1_EN,
  input  logic               RD2_EN,
  input  logic [ASIZE-1:0]   WR1_START_ADDR,
  input  logic [ASIZE-1:0]   WR2_START_ADDR,
  input  logic [ASIZE-1:0]   RD1_START_ADDR,
  input  logic [ASIZE-1:0]   RD2_START_ADDR,
  input  logic [ASIZE-1:0]   WR1_MAX_ADDR,
  input  logic [ASIZE-1:0]   WR2_MAX_ADDR,
  input  logic [ASIZE-1:0]   RD1_MAX_ADDR,
  input  logic [ASIZE-1:0]   RD2_MAX_ADDR,
  input  logic               WR1_LOAD,
  input  logic               WR2_LOAD,
  input  logic               RD1_LOAD,
  input  logic               RD2_LOAD,
  input  logic               DONE,
  input  logic               IN_REQ,
  input  logic               OUT_VALID,
  output logic [ASIZE-1:0]   ADDR,
  output logic               WR,
  output logic               RD,
  output logic [7:0]         LENGTH,
  output logic               WR1_POP,
  output logic               WR2_POP,
  output logic               RD1_PUSH,
  output logic               RD2_PUSH,
  output logic [1:0]         GRANT,
  output logic               BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [USEDW_W:0] WR_MIN = (USEDW_W+1)'(BURST);
  localparam logic [USEDW_W:0] RD_MAX = (USEDW_W+1)'(FIFO_DEPTH - BURST);
  localparam logic [ASIZE+1:0] BURST_A = (ASIZE+2)'(BURST);

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [ASIZE-1:0] ptr_q [4];
  logic [ASIZE-1:0] ptr_d [4];

  logic [ASIZE-1:0] start_a [4];
  logic [ASIZE-1:0] max_a [4];
  logic [3:0]       load_a;
  logic [3:0]       elig;
  logic             win_valid;
  logic [1:0]       win;

  assign start_a[0] = WR1_START_ADDR;
  assign start_a[1] = WR2_START_ADDR;
  assign start_a[2] = RD1_START_ADDR;
  assign start_a[3] = RD2_START_ADDR;
  assign max_a[0]   = WR1_MAX_ADDR;
  assign max_a[1]   = WR2_MAX_ADDR;
  assign max_a[2]   = RD1_MAX_ADDR;
  assign max_a[3]   = RD2_MAX_ADDR;
  assign load_a     = {RD2_LOAD, RD1_LOAD, WR2_LOAD, WR1_LOAD};

  assign elig[0] = {1'b0, WR1_USEDW} >= WR_MIN;
  assign elig[1] = {1'b0, WR2_USEDW} >= WR_MIN;
  assign elig[2] = RD1_EN && ({1'b0, RD1_USEDW} <= RD_MAX);
  assign elig[3] = RD2_EN && ({1'b0, RD2_USEDW} <= RD_MAX);

  // Wrap to START when the burst after this one would cross MAX.
  function automatic logic [ASIZE-1:0] ptr_advance(input logic [ASIZE-1:0] ptr,
                                                   input logic [ASIZE-1:0] start,
                                                   input logic [ASIZE-1:0] max);
    logic [ASIZE+1:0] nxt;
    nxt = {2'b00, ptr} + BURST_A;
    if (nxt + BURST_A > {2'b00, max}) return start;
    return nxt[ASIZE-1:0];
  endfunction

  // Scan from farthest to nearest so the port right after last_grant wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    win_valid = 1'b0;
    win       = last_grant_q;
    for (int i = 4; i >= 1; i--) begin
      if (elig[last_grant_q + 2'(i)]) begin
        win_valid = 1'b1;
        win       = last_grant_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    case (state_q)
      S_IDLE: if (win_valid) begin
        grant_d      = win;
        last_grant_d = win;
        addr_d       = ptr_q[win];
        wr_d         = ~win[1];
        rd_d         = win[1];
        state_d      = S_REQ;
      end
      S_REQ: if (DONE) begin
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        state_d = S_GAP;
      end
      S_GAP: if (!DONE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ptr_d[i] = ptr_q[i];
      if (load_a[i])
        ptr_d[i] = start_a[i];
      else if (state_q == S_REQ && DONE && grant_q == 2'(i))
        ptr_d[i] = ptr_advance(ptr_q[i], start_a[i], max_a[i]);
    end
  end

  always_ff @(posedge REF_CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      for (int i = 0; i < 4; i++) ptr_q[i] <= start_a[i];
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      for (int i = 0; i < 4; i++) ptr_q[i] <= ptr_d[i];
    end
  end

  assign BUSY     = (state_q != S_IDLE);
  assign ADDR     = addr_q;
  assign WR       = wr_q;
  assign RD       = rd_q;
  assign GRANT    = grant_q;
  assign LENGTH   = 8'(BURST);
  assign WR1_POP  = IN_REQ    & BUSY & (grant_q == 2'd0);
  assign WR2_POP  = IN_REQ    & BUSY & (grant_q == 2'd1);
  assign RD1_PUSH = OUT_VALID & BUSY & (grant_q == 2'd2);
  assign RD2_PUSH = OUT_VALID & BUSY & (grant_q == 2'd3);

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Bench for sdram_burst_scheduler: acts as the controller and checks every
// burst against a transaction-level model of grants and address pointers.
module tb_sdram_burst_scheduler;
  localparam int ASIZE      = 22;
  localparam int USEDW_W    = 9;
  localparam int FIFO_DEPTH = 256;
  localparam int BURST      = 8;

  logic               REF_CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic [USEDW_W-1:0] usedw [4];
  logic               rd_en [2];
  logic [ASIZE-1:0]   start_c [4];
  logic [ASIZE-1:0]   max_c [4];
  logic               load [4];
  logic               DONE, IN_REQ, OUT_VALID;
  logic [ASIZE-1:0]   ADDR;
  logic               WR, RD, WR1_POP, WR2_POP, RD1_PUSH, RD2_PUSH, BUSY;
  logic [7:0]         LENGTH;
  logic [1:0]         GRANT;

  sdram_burst_scheduler #(
    .ASIZE(ASIZE), .USEDW_W(USEDW_W), .FIFO_DEPTH(FIFO_DEPTH), .BURST(BURST)
  ) dut (
    .REF_CLK(REF_CLK), .RESET_N(RESET_N),
    .WR1_USEDW(usedw[0]), .WR2_USEDW(usedw[1]), .RD1_USEDW(usedw[2]), .RD2_USEDW(usedw[3]),
    .RD1_EN(rd_en[0]), .RD2_EN(rd_en[1]),
    .WR1_START_ADDR(start_c[0]), .WR2_START_ADDR(start_c[1]),
    .RD1_START_ADDR(start_c[2]), .RD2_START_ADDR(start_c[3]),
    .WR1_MAX_ADDR(max_c[0]), .WR2_MAX_ADDR(max_c[1]),
    .RD1_MAX_ADDR(max_c[2]), .RD2_MAX_ADDR(max_c[3]),
    .WR1_LOAD(load[0]), .WR2_LOAD(load[1]), .RD1_LOAD(load[2]), .RD2_LOAD(load[3]),
    .DONE(DONE), .IN_REQ(IN_REQ), .OUT_VALID(OUT_VALID),
    .ADDR(ADDR), .WR(WR), .RD(RD), .LENGTH(LENGTH),
    .WR1_POP(WR1_POP), .WR2_POP(WR2_POP), .RD1_PUSH(RD1_PUSH), .RD2_PUSH(RD2_PUSH),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 REF_CLK = ~REF_CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr [4];
  int m_last = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_elig(input int p);
    if (p < 2) return int'(usedw[p]) >= BURST;
    return rd_en[p-2] && (int'(usedw[p]) <= FIFO_DEPTH - BURST);
  endfunction

  function automatic int m_pick();
    for (int i = 1; i <= 4; i++)
      if (m_elig((m_last + i) % 4)) return (m_last + i) % 4;
    return -1;
  endfunction

  function automatic int m_next(input int p);
    int nxt;
    nxt = m_ptr[p] + BURST;
    return (nxt + BURST > int'(max_c[p])) ? int'(start_c[p]) : nxt;
  endfunction

  // One clock: model updates at the edge, then inputs are re-driven at negedge.
  task automatic tick(input int adv_port);
    @(posedge REF_CLK);
    if (!RESET_N) begin
      for (int p = 0; p < 4; p++) m_ptr[p] = int'(start_c[p]);
      m_last = 3;
    end else begin
      if (adv_port >= 0) m_ptr[adv_port] = m_next(adv_port);
      for (int p = 0; p < 4; p++) if (load[p]) m_ptr[p] = int'(start_c[p]);
    end
    @(negedge REF_CLK);
    for (int p = 0; p < 4; p++) load[p] = 1'b0;
  endtask

  task automatic rand_load(input int pct);
    for (int p = 0; p < 4; p++) load[p] = ($urandom_range(99) < pct);
  endtask

  task automatic strobes(input bit busy_e, input int g);
    logic [3:0] exp;
    IN_REQ    = 1'($urandom_range(1));
    OUT_VALID = 1'($urandom_range(1));
    #1;
    exp = {OUT_VALID & busy_e & (g == 3), OUT_VALID & busy_e & (g == 2),
           IN_REQ & busy_e & (g == 1), IN_REQ & busy_e & (g == 0)};
    check("strobes", {RD2_PUSH, RD1_PUSH, WR2_POP, WR1_POP}, exp);
  endtask

  // Starts at negedge with the DUT idle and fill levels already driven.
  task automatic burst(input int hold, input bit do_reset, input int load_pct,
                       input bit load_at_done);
    int w;
    logic [31:0] exp_addr;
    logic [USEDW_W-1:0] saved [4];
    w = m_pick();
    if (w < 0) begin
      rand_load(load_pct);
      tick(-1);
      check("idle_busy", BUSY, 0);
      check("idle_wrrd", {WR, RD}, 0);
      return;
    end
    exp_addr = m_ptr[w];
    m_last   = w;
    rand_load(load_pct);
    tick(-1);
    check("req_grant", GRANT, w);
    check("req_addr", ADDR, exp_addr);
    check("req_wrrd", {WR, RD}, {w < 2, w >= 2});
    check("req_busy", BUSY, 1);
    saved = usedw;
    for (int k = 0; k < hold; k++) begin
      for (int p = 0; p < 4; p++) usedw[p] = USEDW_W'($urandom);
      rand_load(load_pct);
      strobes(1, w);
      tick(-1);
      check("hold_grant", GRANT, w);
      check("hold_addr", ADDR, exp_addr);
      check("hold_wrrd", {WR, RD}, {w < 2, w >= 2});
    end
    usedw = saved;
    if (do_reset) begin
      RESET_N = 1'b0;
      tick(-1);
      RESET_N = 1'b1;
      check("rst_wrrd", {WR, RD}, 0);
      check("rst_busy", BUSY, 0);
      check("rst_grant", GRANT, 0);
      check("rst_addr", ADDR, 0);
      return;
    end
    DONE = 1'b1;
    rand_load(load_pct);
    if (load_at_done) load[w] = 1'b1;
    strobes(1, w);
    tick(w);
    check("gap_wrrd", {WR, RD}, 0);
    check("gap_busy", BUSY, 1);
    for (int k = 0; k < int'($urandom_range(2)); k++) begin
      strobes(1, w);
      tick(-1);
      check("gap_hold", BUSY, 1);
    end
    DONE = 1'b0;
    strobes(1, w);
    tick(-1);
    check("gap_exit", BUSY, 0);
    strobes(0, w);
  endtask

  task automatic all_off();
    for (int p = 0; p < 4; p++) usedw[p] = (p < 2) ? 9'd0 : 9'd300;
    rd_en[0] = 1'b0;
    rd_en[1] = 1'b0;
  endtask

  initial begin
    DONE = 1'b0; IN_REQ = 1'b0; OUT_VALID = 1'b0;
    for (int p = 0; p < 4; p++) begin
      load[p]    = 1'b0;
      start_c[p] = ASIZE'(32'h1000 * p);
      max_c[p]   = ASIZE'(32'h1000 * p + 32'h40);
    end
    start_c[0] = 22'h100;
    max_c[0]   = 22'h200;
    all_off();

    // Reset state
    tick(-1);
    tick(-1);
    check("reset_busy", BUSY, 0);
    check("reset_wrrd", {WR, RD}, 0);
    check("reset_grant", GRANT, 0);
    check("reset_addr", ADDR, 0);
    check("length", LENGTH, BURST);
    strobes(0, 0);
    RESET_N = 1'b1;

    // First bursts from WR1: 0x100 then 0x108
    usedw[0] = 9'd8;
    exp_first_addr: begin
      tick(-1);
      check("first_addr", ADDR, 32'h100);
      check("first_wr", {WR, RD}, 2'b10);
      DONE = 1'b1; tick(0); DONE = 1'b0; tick(-1);
      m_last = 0;
    end
    burst(1, 0, 0, 0);

    // Wrap inside a 0x18-word region
    usedw[0] = 9'd0;
    start_c[0] = 22'h0; max_c[0] = 22'h18; load[0] = 1'b1;
    tick(-1);
    usedw[0] = 9'd8;
    for (int i = 0; i < 4; i++) burst(0, 0, 0, 0);

    // Eligibility boundaries
    all_off();
    usedw[1] = 9'd7;
    for (int i = 0; i < 3; i++) burst(0, 0, 0, 0);
    usedw[1] = 9'd8;
    burst(0, 0, 0, 0);
    all_off();
    rd_en[0] = 1'b1; usedw[2] = 9'd249;
    burst(0, 0, 0, 0);
    usedw[2] = 9'd248;
    burst(1, 0, 0, 0);
    rd_en[0] = 1'b0; usedw[2] = 9'd0;
    burst(0, 0, 0, 0);

    // Round-robin after reset: 0,1,2,3,0
    all_off();
    RESET_N = 1'b0; tick(-1); RESET_N = 1'b1;
    usedw[0] = 9'd8; usedw[1] = 9'd8; usedw[2] = 9'd0; usedw[3] = 9'd0;
    rd_en[0] = 1'b1; rd_en[1] = 1'b1;
    for (int i = 0; i < 5; i++) burst(2, 0, 0, 0);

    // Reset mid-burst, then LOAD coinciding with DONE
    all_off();
    usedw[1] = 9'd9;
    burst(1, 0, 0, 0);
    burst(2, 1, 0, 0);
    burst(1, 0, 0, 1);
    burst(1, 0, 0, 0);

    // Randomised traffic over small random regions
    for (int p = 0; p < 4; p++) begin
      start_c[p] = ASIZE'($urandom_range(0, 32'hFFFFF));
      max_c[p]   = start_c[p] + ASIZE'(BURST * $urandom_range(1, 5) + $urandom_range(0, 7));
    end
    all_off();
    RESET_N = 1'b0; tick(-1); RESET_N = 1'b1;
    for (int n = 0; n < 120; n++) begin
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(2))
          0: usedw[p] = 9'd7;
          1: usedw[p] = 9'd8;
          default: usedw[p] = USEDW_W'($urandom);
        endcase
        case ($urandom_range(2))
          0: usedw[p+2] = 9'd248;
          1: usedw[p+2] = 9'd249;
          default: usedw[p+2] = USEDW_W'($urandom);
        endcase
        rd_en[p] = 1'($urandom_range(1));
      end
      burst($urandom_range(3), ($urandom_range(19) == 0), 5, ($urandom_range(9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
